// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one uart transmitter.
// Loads each granted byte once and sequences ld_tx_data/tx_empty.
module uart_tx_arbiter #(
  parameter int NREQ         = 4,
  parameter int DW           = 8,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic                    txclk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*DW-1:0]      req_data,
  output logic [NREQ-1:0]         req_ack,
  input  logic                    err_clr,
  output logic [DW-1:0]           tx_data,
  output logic                    ld_tx_data,
  output logic                    tx_enable,
  input  logic                    tx_empty,
  output logic [$clog2(NREQ)-1:0] grant_id,
  output logic                    busy,
  output logic                    err_timeout
);

  localparam int IW = $clog2(NREQ);
  localparam int SW = IW + 1;
  localparam int CW = $clog2(BUSY_TIMEOUT);

  // the counter trips on the cycle it would reach BUSY_TIMEOUT-1
  localparam logic [CW-1:0] CNT_LAST = CW'(BUSY_TIMEOUT - 2);
  localparam logic [IW-1:0] ID_LAST  = IW'(NREQ - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  state_t        state;
  logic [IW-1:0] rr_ptr;
  logic [CW-1:0] to_cnt;
  logic          win_valid;
  logic [IW-1:0] win_id;
  logic [SW-1:0] sum;
  logic          can_grant;

  // first requester at or above rr_ptr, wrapping past NREQ-1
  always_comb begin
    win_valid = 1'b0;
    win_id    = '0;
    sum       = '0;
    for (int i = 0; i < NREQ; i++) begin
      sum = {1'b0, rr_ptr} + SW'(i);
      if (sum >= SW'(NREQ)) begin
        sum = sum - SW'(NREQ);
      end
      if (!win_valid && req[sum[IW-1:0]]) begin
        win_valid = 1'b1;
        win_id    = sum[IW-1:0];
      end
    end
  end

  // uart must be enabled for a full cycle and idle before a grant
  always_comb begin
    can_grant = enable & tx_enable & tx_empty & win_valid;
  end

  // arbiter fsm with registered outputs
  always_ff @(posedge txclk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      to_cnt      <= '0;
      tx_data     <= '0;
      ld_tx_data  <= 1'b0;
      req_ack     <= '0;
      tx_enable   <= 1'b0;
      grant_id    <= '0;
      busy        <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      tx_enable  <= enable;
      ld_tx_data <= 1'b0;
      req_ack    <= '0;
      if (err_clr) begin
        err_timeout <= 1'b0;
      end
      unique case (state)
        IDLE: begin
          if (can_grant) begin
            tx_data    <= req_data[win_id*DW +: DW];
            grant_id   <= win_id;
            ld_tx_data <= 1'b1;
            req_ack    <= NREQ'(1) << win_id;
            busy       <= 1'b1;
            state      <= LOAD;
          end
        end
        LOAD: begin
          rr_ptr <= (grant_id == ID_LAST) ? '0
                                          : grant_id + 1'b1;
          to_cnt <= '0;
          state  <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (!tx_empty) begin
            state <= WAIT_DONE;
          end else if (to_cnt == CNT_LAST) begin
            err_timeout <= 1'b1;
            busy        <= 1'b0;
            state       <= IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (tx_empty) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
